// File: rtl/sevenseg_pkg.sv
// Shared constants for the 4-digit hex 7-segment scanner.
// Pure declarations, no logic.
// No flow control.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;

    // All segments dark / all digits disabled (active-low outputs).
    localparam seg_t SEG_OFF = 7'h7F;
    localparam an_t  AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam seg_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sevenseg_if.sv
// Bundle of debug-value inputs and display pin outputs for the scanner.
// No latency (wires only).
// No flow control; the display side is free-running.
interface sevenseg_if;
    logic [15:0] test_value;
    logic        blank_lz;
    logic        freeze;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_strobe;

    // Side that supplies the value and watches the pins.
    modport master (
        output test_value, blank_lz, freeze,
        input  seg_n, an_n, dp_n, frame_strobe
    );

    // The scanner itself.
    modport slave (
        input  test_value, blank_lz, freeze,
        output seg_n, an_n, dp_n, frame_strobe
    );
endinterface

// File: rtl/sevenseg_hex_to_7seg.sv
// Nibble to active-low 7-segment pattern decoder.
// Combinational, zero latency.
// No flow control.
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    // Straight table lookup.
    always_comb begin
        seg_o = SEG_HEX[nib_i];
    end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexes a 16-bit value as four hex digits on a common-anode display.
// Outputs trail the digit index by one cycle; value is sampled once per frame.
// No backpressure; scanning is free-running, freeze only blocks the frame capture.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        CLK,
    input  logic        Reset,
    sevenseg_if.slave   bus
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          strobe_q, strobe_d;
    seg_t          seg_q, seg_d;
    an_t           an_q, an_d;

    logic          tick;
    logic          capture;
    logic [3:0]    nib;
    logic [15:0]   upper;
    logic          blank;
    seg_t          seg_dec;

    hex_to_7seg u_dec (
        .nib_i (nib),
        .seg_o (seg_dec)
    );

    // Divider, digit index and frame capture next-state.
    always_comb begin
        tick     = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        // Capture only at the very end of digit 3 so a frame never mixes two values.
        capture  = tick && (idx_q == 2'd3) && !bus.freeze;
        shadow_d = capture ? bus.test_value : shadow_q;
        strobe_d = capture;
    end

    // Segment/anode pattern for the digit currently selected by idx_q.
    always_comb begin
        nib   = shadow_q[{idx_q, 2'b00} +: 4];
        // Digit k is a leading zero when every nibble at or above k is zero.
        upper = shadow_q >> {idx_q, 2'b00};
        blank = bus.blank_lz && (idx_q != 2'd0) && (upper == 16'h0000);
        an_d  = blank ? AN_OFF  : ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_OFF : seg_dec;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            strobe_q <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign bus.seg_n        = seg_q;
    assign bus.an_n         = an_q;
    assign bus.dp_n         = 1'b1;
    assign bus.frame_strobe = strobe_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboarded bench for sevenseg_scanner with a short refresh divider.
// Expected pins are computed each edge and compared 1 ns later.
// Inputs change only between edges.
module tb_sevenseg_scanner;

    localparam int RD = 4;

    logic CLK = 1'b0;
    logic Reset;

    sevenseg_if bus ();

    sevenseg_scanner #(.REFRESH_DIV(RD)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       strobe;
    } exp_t;

    exp_t        sb_q [$];
    int          total = 0;
    int          bad   = 0;
    int          m_phase = 0;
    logic [15:0] m_shadow = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Reference: phase = edges since reset within a 4*RD frame.
    task automatic model_edge();
        exp_t e;
        int   d;
        logic all_zero;
        if (Reset) begin
            e = '{seg: 7'h7F, an: 4'hF, strobe: 1'b0};
            m_phase  = 0;
            m_shadow = 16'h0000;
        end else begin
            d = m_phase / RD;
            all_zero = 1'b1;
            for (int j = d; j < 4; j++)
                if (m_shadow[4*j +: 4] != 4'h0) all_zero = 1'b0;
            if (bus.blank_lz && d > 0 && all_zero) begin
                e.seg = 7'h7F;
                e.an  = 4'hF;
            end else begin
                e.seg = ref_hex(m_shadow[4*d +: 4]);
                e.an  = 4'hF;
                e.an[d] = 1'b0;
            end
            e.strobe = (m_phase == 4*RD - 1) && !bus.freeze;
            if (e.strobe) m_shadow = bus.test_value;
            m_phase = (m_phase + 1) % (4*RD);
        end
        sb_q.push_back(e);
    endtask

    task automatic tick_cycle();
        exp_t e;
        @(posedge CLK);
        model_edge();
        #1;
        e = sb_q.pop_front();
        chk("seg", bus.seg_n, e.seg);
        chk("an", bus.an_n, e.an);
        chk("strobe", bus.frame_strobe, e.strobe);
        chk("dp", bus.dp_n, 1);
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!bus.frame_strobe && n < 200);
        chk("strobe_seen", bus.frame_strobe, 1);
    endtask

    // Called in the cycle right after a capture; checks the four digits of that frame.
    task automatic show_frame(input string tag, input logic [27:0] segs, input logic [15:0] ans);
        for (int k = 0; k < 4; k++) begin
            tick_cycle();
            chk({tag, "_an"}, bus.an_n, ans[4*k +: 4]);
            chk({tag, "_seg"}, bus.seg_n, segs[7*k +: 7]);
            for (int r = 1; r < RD; r++) tick_cycle();
        end
    endtask

    task automatic frame_check(input string tag, input logic [27:0] segs, input logic [15:0] ans);
        wait_strobe();
        show_frame(tag, segs, ans);
    endtask

    initial begin
        int n;
        int hits;

        Reset          = 1'b1;
        bus.test_value = 16'h1234;
        bus.blank_lz   = 1'b0;
        bus.freeze     = 1'b0;

        // 1: reset, startup and first capture
        repeat (3) tick_cycle();
        chk("rst_an", bus.an_n, 4'hF);
        chk("rst_seg", bus.seg_n, 7'h7F);
        chk("rst_strobe", bus.frame_strobe, 0);
        Reset = 1'b0;
        tick_cycle();
        chk("first_an", bus.an_n, 4'hE);
        chk("first_seg", bus.seg_n, 7'h40);
        frame_check("f1234", {7'h79, 7'h24, 7'h30, 7'h19}, {4'h7, 4'hB, 4'hD, 4'hE});

        // 2: leading-zero blanking, then unblanked
        bus.test_value = 16'h00A0;
        bus.blank_lz   = 1'b1;
        frame_check("blank", {7'h7F, 7'h7F, 7'h08, 7'h40}, {4'hF, 4'hF, 4'hD, 4'hE});
        bus.blank_lz = 1'b0;
        frame_check("noblank", {7'h40, 7'h40, 7'h08, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE});

        // 3: all-zero value with blanking keeps a single 0
        bus.test_value = 16'h0000;
        bus.blank_lz   = 1'b1;
        frame_check("zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'hE});

        // 4: freeze holds the shadow across three frames
        bus.blank_lz   = 1'b0;
        bus.test_value = 16'hBEEF;
        frame_check("beef", {7'h03, 7'h06, 7'h06, 7'h0E}, {4'h7, 4'hB, 4'hD, 4'hE});
        bus.freeze     = 1'b1;
        bus.test_value = 16'h1111;
        n = 0;
        hits = 0;
        for (int c = 0; c < 12*RD; c++) begin
            tick_cycle();
            if (bus.frame_strobe) n++;
            if (bus.seg_n == 7'h79) hits++;
        end
        chk("frz_strobes", n, 0);
        chk("frz_leak", hits, 0);
        bus.freeze = 1'b0;
        frame_check("f1111", {7'h79, 7'h79, 7'h79, 7'h79}, {4'h7, 4'hB, 4'hD, 4'hE});

        // 5: reset in the middle of digit 2
        wait_strobe();
        repeat (2*RD + 2) tick_cycle();
        Reset = 1'b1;
        tick_cycle();
        chk("mrst_an", bus.an_n, 4'hF);
        chk("mrst_seg", bus.seg_n, 7'h7F);
        chk("mrst_strobe", bus.frame_strobe, 0);
        Reset = 1'b0;
        tick_cycle();
        chk("mrst_d0_an", bus.an_n, 4'hE);
        chk("mrst_d0_seg", bus.seg_n, 7'h40);
        n = 1;
        while (!bus.frame_strobe && n < 100) begin
            tick_cycle();
            n++;
        end
        chk("mrst_strobe_dist", n, 4*RD);

        // 6: value change right after capture does not tear the frame
        bus.test_value = 16'h1234;
        wait_strobe();
        bus.test_value = 16'h5678;
        show_frame("hold1234", {7'h79, 7'h24, 7'h30, 7'h19}, {4'h7, 4'hB, 4'hD, 4'hE});
        frame_check("f5678", {7'h12, 7'h02, 7'h78, 7'h00}, {4'h7, 4'hB, 4'hD, 4'hE});

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
